calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Sequences the calculator's shared 8-bit ripple add/subtract unit.
- Accepts one operation at a time: ADD, SUB, CMP or unsigned MUL.
- Drives the adder's operand and mode inputs, registers its sum and flags, and reports completion.
- MUL is computed by shift-and-add: WIDTH iterations through the same adder.

Parameters:
- WIDTH, 8, operand width. Only 8 is supported because the shared adder is 8-bit.
- ITERS, WIDTH, number of MUL iterations.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  operation request; sampled only in IDLE
- op  in  2  operation code, see Behaviour
- opa  in  WIDTH  operand A (MUL: multiplicand)
- opb  in  WIDTH  operand B (MUL: multiplier)
- busy  out  1  high while in EXEC or MUL_ITER
- done  out  1  one-cycle pulse when result and flags are valid
- result  out  2*WIDTH  registered result
- flags  out  4  registered flags {cout, ovr, neg, zero}
- add_a  out  WIDTH  to adder operand A
- add_b  out  WIDTH  to adder operand B
- add_sub  out  1  to adder mode (1 = subtract)
- add_s  in  WIDTH  adder sum
- add_flags  in  4  adder flags {cout, ovr, neg, zero}

Behaviour:
- Op encoding:
  - 00 ADD
  - 01 SUB (A-B)
  - 10 MUL (unsigned, 8x8 to 16-bit)
  - 11 CMP (A-B, flags only)
- Reset: state=IDLE; busy=0, done=0, result=0, flags=0, add_a=0, add_b=0, add_sub=0; iteration counter=0. Reset mid-operation aborts it immediately, and no done pulse is produced.
- Idle adder drive: in IDLE and DONE, add_a, add_b and add_sub are held at 0.
- States: IDLE, EXEC, MUL_ITER, DONE.
- IDLE:
  - start=1 latches opa, opb and op.
  - op!=MUL goes to EXEC.
  - op==MUL goes to MUL_ITER with acc=0, M=opa, Q=opb, cnt=0.
- EXEC (one cycle):
  - add_a=A, add_b=B, add_sub = (op is SUB or CMP).
  - At the clock edge: flags<=add_flags.
  - For ADD and SUB, result<={8'h00, add_s}. For CMP, result is unchanged.
  - Next state DONE.
- MUL_ITER (ITERS cycles):
  - add_a=acc, add_b = Q[0] ? M : 0, add_sub=0.
  - At the edge: {acc, Q} <= {add_flags[3], add_s, Q} >> 1 (17-bit shift right), then cnt<=cnt+1.
  - When cnt==ITERS-1: result<={acc, Q} after the update, and go to DONE.
  - Flags after MUL: cout=0; ovr=(result[15:8]!=0); neg=result[15]; zero=(result==0).
- DONE (one cycle): done=1, busy=0, then go to IDLE. start in DONE is ignored.
- Ignored requests: start while busy or in DONE is ignored, with no queueing. op, opa and opb are don't-care outside the accepting cycle.
- Latency (start sampled at edge N):
  - ADD/SUB/CMP: done high during the cycle after edge N+1.
  - MUL: done high during the cycle after edge N+ITERS.
  - Back-to-back throughput: one op per 3 cycles (ADD/SUB/CMP) or per ITERS+2 cycles (MUL).
- Output hold: result and flags keep their values until the next completing operation or reset. CMP updates flags only.
- Overflow: ADD and SUB results are zero-extended, and overflow is reported only through flags.

Decomposition:
- Shared package calc_pkg:
  - op encodings OP_ADD, OP_SUB, OP_MUL, OP_CMP;
  - state enum;
  - flag bit indices FLG_COUT=3, FLG_OVR=2, FLG_NEG=1, FLG_ZERO=0.
- No sub-module. The adder stays an external shared instance wired at the calculator top level; the FSM, counter and shift register live in this block.

Test Plan:
- ADD 100+27: result=0x007F, flags=0000, done exactly 2 edges after start.
- ADD 0x7F+0x01: result=0x0080, flags=0110. Then SUB 5-5: result=0x0000, flags=1001.
- CMP 3-7 after a prior ADD result of 0x007F: result stays 0x007F, flags=0010 (neg=1, cout=0).
- MUL 255*255: result=0xFE01, flags=0110, done at edge N+8. MUL 0*200: result=0, flags=0001.
- A second start during busy MUL (any op): it is ignored, there is exactly one done pulse, and the result is that of the first op. Also check add_a, add_b and add_sub are 0 in IDLE.
- rst=1 at iteration 4 of MUL 12*12: the next cycle shows IDLE, busy=0, result=0, flags=0, with no done. Then a fresh MUL 12*12 gives 0x0090.

Source files
------------

// File: rtl/calc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
//   Shared definitions for the calculator sequencer: operation encodings,
//   sequencer state encoding and the bit positions inside the 4-bit flag word
//   {cout, ovr, neg, zero} used by both the shared adder and the sequencer.
// -----------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_CMP = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL_ITER,
    ST_DONE
  } state_t;

  localparam int FLAGS_W   = 4;
  localparam int FLG_COUT  = 3;
  localparam int FLG_OVR   = 2;
  localparam int FLG_NEG   = 1;
  localparam int FLG_ZERO  = 0;

endpackage

// File: rtl/calc_sequencer_if.sv
// -----------------------------------------------------------------------------
// calc_sequencer_if
//   Request/response bus between a client and the calculator sequencer.
//   Signals:
//     start  - operation request (sampled by the sequencer only when idle)
//     op     - operation code (see calc_pkg::op_t)
//     opa    - operand A / MUL multiplicand
//     opb    - operand B / MUL multiplier
//     busy   - sequencer is executing an operation
//     done   - one-cycle completion pulse
//     result - registered 2*WIDTH result
//     flags  - registered {cout, ovr, neg, zero}
//   Modports: master (client side), slave (sequencer side).
// -----------------------------------------------------------------------------
interface calc_sequencer_if #(
  parameter int WIDTH = 8
);

  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [3:0]           flags;

  modport master (
    output start, op, opa, opb,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, result, flags
  );

endinterface

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
//   Sequences the calculator's shared 8-bit ripple add/subtract unit for
//   ADD, SUB, CMP (flags only) and unsigned MUL (shift-and-add, ITERS passes
//   through the same adder).
//
//   Ports:
//     clk       - system clock, all state on the rising edge
//     rst       - synchronous active-high reset; aborts any operation
//     bus       - calc_sequencer_if.slave: start/op/opa/opb in,
//                 busy/done/result/flags out
//     add_a     - shared adder operand A
//     add_b     - shared adder operand B
//     add_sub   - shared adder mode (1 = subtract)
//     add_s     - shared adder sum
//     add_flags - shared adder flags {cout, ovr, neg, zero}
//
//   All outputs are registered. The adder drive is loaded one cycle ahead so
//   that during EXEC / MUL_ITER the adder already sees the operands for the
//   current step, and its combinational answer is captured at the next edge.
// -----------------------------------------------------------------------------
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITERS = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  calc_sequencer_if.slave      bus,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_sub,
  input  logic [WIDTH-1:0]     add_s,
  input  logic [FLAGS_W-1:0]   add_flags
);

  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  state_t                 state_reg;
  op_t                    op_reg;
  logic [WIDTH-1:0]       m_reg;
  logic [WIDTH-1:0]       acc_reg;
  logic [WIDTH-1:0]       q_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [2*WIDTH-1:0]     result_reg;
  logic [FLAGS_W-1:0]     flags_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic [WIDTH-1:0]       add_a_reg;
  logic [WIDTH-1:0]       add_b_reg;
  logic                   add_sub_reg;

  op_t                    cmd_op;
  logic [WIDTH-1:0]       acc_next;
  logic [WIDTH-1:0]       q_next;
  logic [FLAGS_W-1:0]     mul_flags;
  logic                   mul_last;

  assign cmd_op = op_t'(bus.op);

  // One shift-and-add step: {cout, sum, Q} shifted right by one. The adder's
  // carry becomes the new accumulator MSB and the sum LSB moves into Q.
  assign acc_next = {add_flags[FLG_COUT], add_s[WIDTH-1:1]};
  assign q_next   = {add_s[0], q_reg[WIDTH-1:1]};
  assign mul_last = (cnt_reg == CNT_W'(ITERS - 1));

  // Flags for a finished product; ovr means the product does not fit WIDTH.
  always_comb begin
    mul_flags           = '0;
    mul_flags[FLG_COUT] = 1'b0;
    mul_flags[FLG_OVR]  = |acc_next;
    mul_flags[FLG_NEG]  = acc_next[WIDTH-1];
    mul_flags[FLG_ZERO] = ~|{acc_next, q_next};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      op_reg      <= OP_ADD;
      m_reg       <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      flags_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      add_a_reg   <= '0;
      add_b_reg   <= '0;
      add_sub_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            op_reg   <= cmd_op;
            busy_reg <= 1'b1;
            if (cmd_op == OP_MUL) begin
              m_reg       <= bus.opa;
              q_reg       <= bus.opb;
              acc_reg     <= '0;
              cnt_reg     <= '0;
              // First step adds M to a zero accumulator if Q[0] is set.
              add_a_reg   <= '0;
              add_b_reg   <= bus.opb[0] ? bus.opa : '0;
              add_sub_reg <= 1'b0;
              state_reg   <= ST_MUL_ITER;
            end else begin
              add_a_reg   <= bus.opa;
              add_b_reg   <= bus.opb;
              add_sub_reg <= (cmd_op == OP_SUB) || (cmd_op == OP_CMP);
              state_reg   <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          flags_reg <= add_flags;
          if (op_reg != OP_CMP) begin
            result_reg <= {{WIDTH{1'b0}}, add_s};
          end
          add_a_reg   <= '0;
          add_b_reg   <= '0;
          add_sub_reg <= 1'b0;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b1;
          state_reg   <= ST_DONE;
        end

        ST_MUL_ITER: begin
          acc_reg <= acc_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (mul_last) begin
            result_reg  <= {acc_next, q_next};
            flags_reg   <= mul_flags;
            add_a_reg   <= '0;
            add_b_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= ST_DONE;
          end else begin
            // Preload the adder for the next step from the post-shift values.
            add_a_reg <= acc_next;
            add_b_reg <= q_next[0] ? m_reg : '0;
          end
          add_sub_reg <= 1'b0;
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign add_a      = add_a_reg;
  assign add_b      = add_b_reg;
  assign add_sub    = add_sub_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.flags  = flags_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
//   Self-checking bench for calc_sequencer. Provides a behavioural model of
//   the shared 8-bit adder, drives directed and random operations and checks
//   result, flags, latency, throughput, ignored requests and reset abort
//   against a reference model based on plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic [3:0]  fl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  calc_sequencer_if #(.WIDTH(W)) bus();

  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_sub;
  logic [W-1:0] add_s;
  logic [3:0]   add_flags;

  calc_sequencer #(.WIDTH(W), .ITERS(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sub   (add_sub),
    .add_s     (add_s),
    .add_flags (add_flags)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_result;
  logic [3:0]  m_flags;

  // 8-bit add/subtract from integer arithmetic: returns {cout,ovr,neg,zero,sum}.
  function automatic logic [11:0] alu8(input logic [7:0] a, input logic [7:0] b,
                                       input logic sub);
    int ua;
    int ub;
    int sa;
    int sb;
    int u;
    int s;
    logic [7:0] r;
    logic c;
    logic v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u = ua - ub;
      s = sa - sb;
      c = (ua >= ub);
    end else begin
      u = ua + ub;
      s = sa + sb;
      c = (u > 255);
    end
    r = u[7:0];
    v = (s > 127) || (s < -128);
    return {c, v, r[7], (r == 8'd0), r};
  endfunction

  // Shared adder instance as seen by the sequencer.
  always_comb {add_flags, add_s} = alu8(add_a, add_b, add_sub);

  // Reference model: what a completed operation leaves on result/flags.
  function automatic void model_op(input logic [1:0] op, input logic [7:0] a,
                                   input logic [7:0] b);
    logic [11:0] t;
    int p;
    logic [15:0] pv;
    case (op)
      2'b00: begin
        t = alu8(a, b, 1'b0);
        m_result = {8'h00, t[7:0]};
        m_flags  = t[11:8];
      end
      2'b01: begin
        t = alu8(a, b, 1'b1);
        m_result = {8'h00, t[7:0]};
        m_flags  = t[11:8];
      end
      2'b11: begin
        t = alu8(a, b, 1'b1);
        m_flags = t[11:8];
      end
      default: begin
        p  = int'(a) * int'(b);
        pv = p[15:0];
        m_result = pv;
        m_flags  = {1'b0, (p > 255), pv[15], (p == 0)};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
    return (op == 2'b10) ? W : 1;
  endfunction

  // Issue one request (called at a negedge) and wait for its done pulse.
  // lat = edges after the sampling edge at which done is seen (-1 on timeout),
  // done_after = done one cycle later, t0 = cycle stamp of the sampling edge.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic done_after, output int t0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    lat = -1;
    done_after = 1'b0;
    t0 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        t0 = cyc;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.opa   = 8'($urandom);
        bus.opb   = 8'($urandom);
      end
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    if (lat >= 0) begin
      @(negedge clk);
      done_after = bus.done;
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    n_cmp++;
    if (bus.result !== 16'h0000 || bus.flags !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_out: result=%h flags=%b want 0000 0000", bus.result, bus.flags);
    end
    n_cmp++;
    if ({add_a, add_b, add_sub} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_drive: a=%h b=%h sub=%b want 0", add_a, add_b, add_sub);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || {add_a, add_b, add_sub} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b done=%b a=%h b=%h sub=%b want all 0",
               bus.busy, bus.done, add_a, add_b, add_sub);
    end
    m_result = 16'h0000;
    m_flags  = 4'h0;
    $display("test_reset: done");
  endtask

  task automatic test_directed;
    vec_t tbl [7];
    int lat;
    logic da;
    int t0;
    tbl = '{
      '{2'b00, 8'd100, 8'd27,  16'h007F, 4'b0000},
      '{2'b00, 8'h7F,  8'h01,  16'h0080, 4'b0110},
      '{2'b01, 8'd5,   8'd5,   16'h0000, 4'b1001},
      '{2'b00, 8'd100, 8'd27,  16'h007F, 4'b0000},
      '{2'b11, 8'd3,   8'd7,   16'h007F, 4'b0010},
      '{2'b10, 8'hFF,  8'hFF,  16'hFE01, 4'b0110},
      '{2'b10, 8'd0,   8'd200, 16'h0000, 4'b0001}
    };
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, da, t0);
      model_op(tbl[i].op, tbl[i].a, tbl[i].b);
      $display("directed[%0d]: op=%0d a=%h b=%h -> result=%h flags=%b lat=%0d",
               i, tbl[i].op, tbl[i].a, tbl[i].b, bus.result, bus.flags, lat);
      n_cmp++;
      if (bus.result !== tbl[i].res || bus.flags !== tbl[i].fl) begin
        n_bad++;
        $display("FAIL directed_val[%0d]: result=%h flags=%b want %h %b",
                 i, bus.result, bus.flags, tbl[i].res, tbl[i].fl);
      end
      n_cmp++;
      if (bus.result !== m_result || bus.flags !== m_flags) begin
        n_bad++;
        $display("FAIL directed_model[%0d]: result=%h flags=%b want %h %b",
                 i, bus.result, bus.flags, m_result, m_flags);
      end
      n_cmp++;
      if (lat !== exp_lat(tbl[i].op) || da !== 1'b0) begin
        n_bad++;
        $display("FAIL directed_lat[%0d]: lat=%0d done_after=%b want %0d 0",
                 i, lat, da, exp_lat(tbl[i].op));
      end
      n_cmp++;
      if ({add_a, add_b, add_sub} !== 17'd0) begin
        n_bad++;
        $display("FAIL idle_drive[%0d]: a=%h b=%h sub=%b want 0", i, add_a, add_b, add_sub);
      end
    end
  endtask

  task automatic test_ignored_start;
    logic [7:0] a;
    logic [7:0] b;
    int n_done;
    int first_k;
    logic busy_ok;
    a = 8'($urandom);
    b = 8'($urandom);
    n_done = 0;
    first_k = -1;
    busy_ok = 1'b1;
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    // Keep requesting random ops through busy and the DONE cycle.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k <= W) begin
        bus.start = 1'b1;
        bus.op    = 2'($urandom);
        bus.opa   = 8'($urandom);
        bus.opb   = 8'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (k < W && bus.busy !== 1'b1) busy_ok = 1'b0;
      if (k >= W && bus.busy !== 1'b0) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_k < 0) first_k = k;
      end
    end
    model_op(2'b10, a, b);
    $display("ignored_start: MUL %h*%h -> result=%h dones=%0d at=%0d", a, b,
             bus.result, n_done, first_k);
    n_cmp++;
    if (n_done !== 1 || first_k !== W) begin
      n_bad++;
      $display("FAIL ignored_done: pulses=%0d first=%0d want 1 %0d", n_done, first_k, W);
    end
    n_cmp++;
    if (bus.result !== m_result || bus.flags !== m_flags) begin
      n_bad++;
      $display("FAIL ignored_result: result=%h flags=%b want %h %b",
               bus.result, bus.flags, m_result, m_flags);
    end
    n_cmp++;
    if (busy_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL ignored_busy: busy profile wrong, got ok=%b want 1", busy_ok);
    end
    n_cmp++;
    if ({add_a, add_b, add_sub} !== 17'd0) begin
      n_bad++;
      $display("FAIL ignored_idle_drive: a=%h b=%h sub=%b want 0", add_a, add_b, add_sub);
    end
  endtask

  task automatic test_reset_mid_mul;
    int lat;
    logic da;
    int t0;
    int n_done;
    do_op(2'b00, 8'd100, 8'd27, lat, da, t0);
    model_op(2'b00, 8'd100, 8'd27);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.opa   = 8'd12;
    bus.opb   = 8'd12;
    @(posedge clk);
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done === 1'b1) n_done++;
      if (k == 3) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    m_result = 16'h0000;
    m_flags  = 4'h0;
    $display("reset_mid_mul: busy=%b result=%h flags=%b", bus.busy, bus.result, bus.flags);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0000 ||
        bus.flags !== 4'h0 || {add_a, add_b, add_sub} !== 17'd0) begin
      n_bad++;
      $display("FAIL abort_state: busy=%b done=%b result=%h flags=%b a=%h b=%h want all 0",
               bus.busy, bus.done, bus.result, bus.flags, add_a, add_b);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done: pulses=%0d want 0", n_done);
    end
    do_op(2'b10, 8'd12, 8'd12, lat, da, t0);
    model_op(2'b10, 8'd12, 8'd12);
    $display("reset_mid_mul: fresh MUL 12*12 -> result=%h flags=%b lat=%0d",
             bus.result, bus.flags, lat);
    n_cmp++;
    if (bus.result !== 16'h0090 || bus.flags !== 4'b0000 || lat !== W) begin
      n_bad++;
      $display("FAIL abort_fresh_mul: result=%h flags=%b lat=%0d want 0090 0000 %0d",
               bus.result, bus.flags, lat, W);
    end
  endtask

  task automatic test_random;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int lat;
    logic da;
    int t0;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if (i % 8 == 0) a = 8'hFF;
      if (i % 8 == 1) b = 8'h00;
      if (i % 8 == 2) b = a;
      do_op(op, a, b, lat, da, t0);
      model_op(op, a, b);
      $display("random[%0d]: op=%0d a=%h b=%h -> result=%h flags=%b lat=%0d",
               i, op, a, b, bus.result, bus.flags, lat);
      n_cmp++;
      if (bus.result !== m_result || bus.flags !== m_flags) begin
        n_bad++;
        $display("FAIL random_val[%0d]: result=%h flags=%b want %h %b",
                 i, bus.result, bus.flags, m_result, m_flags);
      end
      n_cmp++;
      if (lat !== exp_lat(op) || da !== 1'b0) begin
        n_bad++;
        $display("FAIL random_lat[%0d]: lat=%0d done_after=%b want %0d 0",
                 i, lat, da, exp_lat(op));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] op;
    logic [1:0] prev_op;
    logic [7:0] a;
    logic [7:0] b;
    int lat;
    logic da;
    int t0;
    int prev_t0;
    prev_op = 2'b00;
    prev_t0 = -1;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = 8'($urandom);
      do_op(op, a, b, lat, da, t0);
      model_op(op, a, b);
      $display("back_to_back[%0d]: op=%0d a=%h b=%h -> result=%h flags=%b gap=%0d",
               i, op, a, b, bus.result, bus.flags, (prev_t0 < 0) ? 0 : t0 - prev_t0);
      n_cmp++;
      if (bus.result !== m_result || bus.flags !== m_flags) begin
        n_bad++;
        $display("FAIL b2b_val[%0d]: result=%h flags=%b want %h %b",
                 i, bus.result, bus.flags, m_result, m_flags);
      end
      if (prev_t0 >= 0) begin
        n_cmp++;
        if (t0 - prev_t0 !== exp_lat(prev_op) + 2) begin
          n_bad++;
          $display("FAIL b2b_gap[%0d]: gap=%0d want %0d", i, t0 - prev_t0,
                   exp_lat(prev_op) + 2);
        end
      end
      prev_op = op;
      prev_t0 = t0;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.opa   = 8'h00;
    bus.opb   = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset;
    test_directed;
    test_ignored_start;
    test_reset_mid_mul;
    test_random;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
